// File: rtl/sync_pkg.sv
// Shared constants and helpers for the boundary synchroniser/filter family.
package sync_pkg;

  localparam int unsigned SYNC_MIN_STAGES = 2;
  localparam int unsigned SYNC_MAX_STAGES = 4;
  localparam int unsigned FILT_MAX        = 255;

  // Smallest w with 2**w >= value; used to size the filter counters.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : sync_pkg

// File: rtl/sync_filter_ch.sv
// One channel: flop-chain synchroniser, consecutive-cycle glitch filter and
// registered rise/fall event pulses.
module sync_filter_ch
  import sync_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter int unsigned FILT    = 4,
  parameter logic        RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  input  logic filt_bypass,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = clog2(FILT + 1);

  logic [STAGES-1:0] chain;
  logic              raw;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              sync_nxt;
  logic              rise_nxt;
  logic              fall_nxt;

  assign raw = chain[STAGES-1];

  // Filter decision: a differing level must persist FILT cycles (or bypass is set).
  always_comb begin
    cnt_nxt  = '0;
    sync_nxt = sync_out;
    rise_nxt = 1'b0;
    fall_nxt = 1'b0;
    if (raw != sync_out) begin
      if (filt_bypass || (cnt == CW'(FILT - 1))) begin
        sync_nxt = raw;
        rise_nxt = raw;
        fall_nxt = ~raw;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  // Chain, filter state and edge flops; reset never produces an edge pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain    <= {STAGES{RST_BIT}};
      sync_out <= RST_BIT;
      cnt      <= '0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      chain    <= {chain[STAGES-2:0], async_in};
      sync_out <= sync_nxt;
      cnt      <= cnt_nxt;
      rise     <= rise_nxt;
      fall     <= fall_nxt;
    end
  end

endmodule : sync_filter_ch

// File: rtl/multi_sync_filter.sv
// CH-channel boundary synchroniser with glitch filtering and edge events.
module multi_sync_filter
  import sync_pkg::*;
#(
  parameter int unsigned    CH      = 8,
  parameter int unsigned    STAGES  = 2,
  parameter int unsigned    FILT    = 4,
  parameter logic [CH-1:0]  RST_VAL = {CH{1'b0}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] async_in,
  input  logic          filt_bypass,
  output logic [CH-1:0] sync_out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          any_event
);

  // Reject illegal configurations at elaboration.
  if ((STAGES < SYNC_MIN_STAGES) || (STAGES > SYNC_MAX_STAGES)) begin : g_bad_stages
    $error("multi_sync_filter: STAGES=%0d outside %0d..%0d",
           STAGES, SYNC_MIN_STAGES, SYNC_MAX_STAGES);
  end
  if ((FILT < 1) || (FILT > FILT_MAX)) begin : g_bad_filt
    $error("multi_sync_filter: FILT=%0d outside 1..%0d", FILT, FILT_MAX);
  end

  // One independent synchroniser/filter per channel.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    sync_filter_ch #(
      .STAGES  (STAGES),
      .FILT    (FILT),
      .RST_BIT (RST_VAL[i])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .async_in    (async_in[i]),
      .filt_bypass (filt_bypass),
      .sync_out    (sync_out[i]),
      .rise        (rise[i]),
      .fall        (fall[i])
    );
  end

  assign any_event = |(rise | fall);

endmodule : multi_sync_filter

// File: tb/tb_multi_sync_filter.sv
// Directed checks of multi_sync_filter: CH=4/STAGES=2/FILT=3 main instance plus
// a STAGES=3/FILT=1/RST_VAL=4'b1010 instance.
module tb_multi_sync_filter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] async_in;
  logic       filt_bypass;
  logic [3:0] sync_out, rise, fall;
  logic       any_event;

  logic       b_rst;
  logic [3:0] b_in;
  logic       b_bypass;
  logic [3:0] b_sync, b_rise, b_fall;
  logic       b_any;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_sync_filter #(.CH(4), .STAGES(2), .FILT(3), .RST_VAL(4'b0000)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .async_in    (async_in),
    .filt_bypass (filt_bypass),
    .sync_out    (sync_out),
    .rise        (rise),
    .fall        (fall),
    .any_event   (any_event)
  );

  multi_sync_filter #(.CH(4), .STAGES(3), .FILT(1), .RST_VAL(4'b1010)) u_dut_b (
    .clk         (clk),
    .rst         (b_rst),
    .async_in    (b_in),
    .filt_bypass (b_bypass),
    .sync_out    (b_sync),
    .rise        (b_rise),
    .fall        (b_fall),
    .any_event   (b_any)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; async_in = 4'hF; filt_bypass = 1'b0;
    b_rst = 1'b1; b_in = 4'b1010; b_bypass = 1'b0;

    // 1. reset with all inputs high, then release
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("rst_sync", 8'(sync_out), 8'h0);
      chk("rst_rise", 8'(rise), 8'h0);
      chk("rst_fall", 8'(fall), 8'h0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("rel_sync", 8'(sync_out), (k >= 5) ? 8'hF : 8'h0);
      chk("rel_rise", 8'(rise), (k == 5) ? 8'hF : 8'h0);
      chk("rel_any", 8'(any_event), (k == 5) ? 8'h1 : 8'h0);
    end
    async_in = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("clr_fall", 8'(fall), (k == 5) ? 8'hF : 8'h0);
    end
    chk("clr_sync", 8'(sync_out), 8'h0);

    // 2. clean step on channel 0, up then down
    async_in = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("step_sync", 8'(sync_out), (k >= 5) ? 8'h1 : 8'h0);
      chk("step_rise", 8'(rise), (k == 5) ? 8'h1 : 8'h0);
      chk("step_fall", 8'(fall), 8'h0);
    end
    async_in = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("stepdn_sync", 8'(sync_out), (k >= 5) ? 8'h0 : 8'h1);
      chk("stepdn_fall", 8'(fall), (k == 5) ? 8'h1 : 8'h0);
      chk("stepdn_rise", 8'(rise), 8'h0);
    end

    // 3. two-cycle pulse rejected, three-cycle pulse accepted
    async_in = 4'b0010;
    ticks(2);
    async_in = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("glitch_sync", 8'(sync_out), 8'h0);
      chk("glitch_rise", 8'(rise), 8'h0);
    end
    async_in = 4'b0010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 3) async_in = 4'b0000;
      chk("pulse3_sync", 8'(sync_out), (k >= 5) ? 8'h2 : 8'h0);
      chk("pulse3_rise", 8'(rise), (k == 5) ? 8'h2 : 8'h0);
    end
    ticks(8);
    chk("pulse3_back", 8'(sync_out), 8'h0);

    // 4. bypass: STAGES+1 latency, then enabling bypass mid-count
    filt_bypass = 1'b1;
    async_in = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("byp_sync", 8'(sync_out), (k >= 3) ? 8'h4 : 8'h0);
      chk("byp_rise", 8'(rise), (k == 3) ? 8'h4 : 8'h0);
    end
    async_in = 4'b0000;
    ticks(4);
    chk("byp_back", 8'(sync_out), 8'h0);
    filt_bypass = 1'b0;
    async_in = 4'b0100;
    ticks(3);
    chk("midcnt_hold", 8'(sync_out), 8'h0);
    filt_bypass = 1'b1;
    tick();
    chk("midcnt_sync", 8'(sync_out), 8'h4);
    chk("midcnt_rise", 8'(rise), 8'h4);
    filt_bypass = 1'b0;
    async_in = 4'b0000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("unbyp_sync", 8'(sync_out), (k >= 5) ? 8'h0 : 8'h4);
      chk("unbyp_fall", 8'(fall), (k == 5) ? 8'h4 : 8'h0);
    end

    // 5. reset in the middle of a count on channel 3
    async_in = 4'b1000;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_sync", 8'(sync_out), 8'h0);
    chk("midrst_rise", 8'(rise), 8'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("postrst_sync", 8'(sync_out), (k >= 5) ? 8'h8 : 8'h0);
      chk("postrst_rise", 8'(rise), (k == 5) ? 8'h8 : 8'h0);
    end
    // reset while sync_out differs from the reset level: no fall pulse
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsthi_sync", 8'(sync_out), 8'h0);
    chk("rsthi_fall", 8'(fall), 8'h0);
    // simultaneous opposite-direction events on channels 0 and 1
    async_in = 4'b0010;
    ticks(8);
    chk("simul_pre", 8'(sync_out), 8'h2);
    async_in = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("simul_sync", 8'(sync_out), (k >= 5) ? 8'h1 : 8'h2);
      chk("simul_rise", 8'(rise), (k == 5) ? 8'h1 : 8'h0);
      chk("simul_fall", 8'(fall), (k == 5) ? 8'h2 : 8'h0);
      chk("simul_any", 8'(any_event), (k == 5) ? 8'h1 : 8'h0);
    end

    // 6. STAGES=3, FILT=1, RST_VAL=4'b1010 instance
    chk("b_rst_sync", 8'(b_sync), 8'hA);
    chk("b_rst_ev", 8'({b_rise, b_fall}), 8'h00);
    b_rst = 1'b0;
    ticks(5);
    chk("b_idle_sync", 8'(b_sync), 8'hA);
    chk("b_idle_any", 8'(b_any), 8'h0);
    b_in = 4'b1011;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("b_step_sync", 8'(b_sync), (k >= 4) ? 8'hB : 8'hA);
      chk("b_step_rise", 8'(b_rise), (k == 4) ? 8'h1 : 8'h0);
    end
    b_in = 4'b1001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("b_fall_sync", 8'(b_sync), (k >= 4) ? 8'h9 : 8'hB);
      chk("b_fall_fall", 8'(b_fall), (k == 4) ? 8'h2 : 8'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_multi_sync_filter

// File: doc/multi_sync_filter.md
Name: multi_sync_filter

Overview:
- Parametrised successor to the team's fixed 2-flop bus synchroniser.
- Synchronises CH independent asynchronous single-bit inputs through a configurable-depth flop chain.
- Each channel then passes a consecutive-cycle glitch filter.
- Produces registered filtered levels plus one-cycle rise/fall event pulses.
- Sits at the chip boundary, between pads/foreign-domain signals and control logic in the clk domain.

Parameters:
- CH, 8: number of independent channels.
- STAGES, 2: synchroniser flop depth; legal range 2..4, elaborate-time error outside it.
- FILT, 4: consecutive cycles a changed level must persist before acceptance; legal 1..255; 1 = no filtering.
- RST_VAL, {CH{1'b0}}: per-channel reset level of the chain, sync_out and the internal filter state.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- async_in  in  CH  asynchronous level inputs, one bit per channel.
- filt_bypass  in  1  synchronous; 1 = behave as FILT=1 and hold all counters at 0.
- sync_out  out  CH  filtered, synchronised level (registered).
- rise  out  CH  one-cycle pulse, high in the same cycle sync_out[i] goes 0->1 (registered).
- fall  out  CH  one-cycle pulse, high in the same cycle sync_out[i] goes 1->0 (registered).
- any_event  out  1  OR-reduction of rise|fall; combinational from registered signals.

Behaviour:
- One clock; reset is synchronous and active-high, on clk and rst.
- Reset: on a posedge with rst=1:
  - all chain flops, sync_out and the filter state load RST_VAL;
  - all counters load 0;
  - rise and fall load 0.
  - rst overrides every other input.
- Chain: per channel, STAGES flops in series. Stage 0 samples async_in[i]; the last stage is raw[i]. No logic between stages.
- Filter, per channel, counter width clog2(FILT+1), evaluated each posedge when rst=0:
  - raw == sync_out: cnt <= 0.
  - raw != sync_out and (cnt == FILT-1 or filt_bypass=1): sync_out <= raw, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any single cycle with raw == sync_out restarts the count, so pulses shorter than FILT cycles at raw are discarded entirely.
- Latency: an async_in change set up before edge 1 appears on sync_out after edge STAGES+FILT. With filt_bypass=1 it appears after edge STAGES+1.
- Edges:
  - rise[i] <= (sync_out[i]==0 && next sync_out[i]==1); fall is the mirror.
  - Each pulse lasts exactly one cycle, coincident with the new sync_out value.
  - A channel never asserts rise and fall in the same cycle.
  - Different channels are fully independent; simultaneous events on several channels are all reported.
- Reset mid-operation:
  - An in-progress count is discarded.
  - The reset itself never generates rise/fall, even if sync_out was not RST_VAL.
  - After release, an input differing from RST_VAL takes the full STAGES+FILT latency, then pulses normally.
- filt_bypass:
  - Asserting it mid-count accepts a pending difference on the next edge.
  - Deasserting it starts counting from 0.
- Counter saturation cannot occur; the maximum value reached is FILT-1.

Decomposition:
- Package sync_pkg:
  - constants SYNC_MIN_STAGES=2, SYNC_MAX_STAGES=4, FILT_MAX=255;
  - a counter-width function clog2.
- Sub-module sync_filter_ch (one channel: chain + filter + edge flops), instantiated CH times by a generate loop.
- Per-channel parameter RST_BIT is taken from RST_VAL[i].
- Top level holds only the generate loop and the any_event OR.

Test Plan (CH=4, STAGES=2, FILT=3, RST_VAL=4'b0000 unless noted):
1. Reset:
   - Stimulus: async_in=4'hF, rst=1 for 3 edges, then released.
   - Required: sync_out=4'h0 and rise=fall=0 throughout reset. After edge 5 post-release, sync_out=4'hF and rise=4'hF for exactly one cycle; any_event=1 for that cycle only.
2. Clean step:
   - Stimulus: async_in[0] 0->1 before edge 1.
   - Required: sync_out[0]=1 after edge 5 and rise[0]=1 for one cycle. Stepping back to 0 gives fall[0]=1 five edges later; rise/fall on other channels stay 0.
3. Glitch reject/accept:
   - Stimulus: async_in[1]=1 held for 2 cycles, then 0.
   - Required: sync_out[1] stays 0 and no rise. Held for 3 cycles instead: sync_out[1]=1 after edge 5.
4. Bypass:
   - Stimulus: filt_bypass=1, async_in[2] 0->1 before edge 1.
   - Required: sync_out[2]=1 after edge 3.
   - Stimulus: toggle filt_bypass 0->1 while cnt=1.
   - Required: accepted on the next edge.
5. Reset mid-filter / simultaneous events:
   - Stimulus: async_in[3] rises and rst pulses at edge 4.
   - Required: no rise; sync_out[3] becomes 1 only at edge 5 after release.
   - Stimulus: channels 0 and 1 change in opposite directions in the same cycle.
   - Required: rise=4'b0001 and fall=4'b0010 in one cycle.
6. Parameter sweep:
   - Stimulus: STAGES=3, FILT=1, RST_VAL=4'b1010.
   - Required: reset drives sync_out=4'b1010. A step appears after edge 4. Illegal STAGES=1 fails elaboration.
